// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: the segment glyph table (active-high,
// bit 0 = segment a ... bit 6 = segment g), the serial reader state
// type, and the bit positions on the tile input/output buses.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_7_ALT = 7'h27;
  localparam logic [6:0] SEG_9_ALT = 7'h67;

  localparam int unsigned FRAME_BITS = 7;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DECODE
  } state_t;

  // Input bus bit positions
  localparam int unsigned IN_CLK    = 0;
  localparam int unsigned IN_RST    = 1;
  localparam int unsigned IN_SDATA  = 2;
  localparam int unsigned IN_STROBE = 3;

  // Output bus bit positions
  localparam int unsigned OUT_DIGIT_LSB = 0;
  localparam int unsigned OUT_DIGIT_MSB = 3;
  localparam int unsigned OUT_VALID     = 4;
  localparam int unsigned OUT_ERR       = 5;
  localparam int unsigned OUT_BUSY      = 6;
  localparam int unsigned OUT_FTOG      = 7;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to hex-digit lookup.
// Ports:
//   pat   [6:0] in  : segment pattern, bit 0 = a ... bit 6 = g
//   hit         out : pattern is a known glyph
//   digit [3:0] out : decoded hex value (0 on a miss)
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic       hit,
  output logic [3:0] digit
);

  always_comb begin
    hit   = 1'b1;
    digit = '0;
    case (pat)
      SEG_0:     digit = 4'h0;
      SEG_1:     digit = 4'h1;
      SEG_2:     digit = 4'h2;
      SEG_3:     digit = 4'h3;
      SEG_4:     digit = 4'h4;
      SEG_5:     digit = 4'h5;
      SEG_6:     digit = 4'h6;
      SEG_7:     digit = 4'h7;
      SEG_8:     digit = 4'h8;
      SEG_9:     digit = 4'h9;
      SEG_A:     digit = 4'hA;
      SEG_B:     digit = 4'hB;
      SEG_C:     digit = 4'hC;
      SEG_D:     digit = 4'hD;
      SEG_E:     digit = 4'hE;
      SEG_F:     digit = 4'hF;
      SEG_7_ALT: digit = 4'h7;
      SEG_9_ALT: digit = 4'h9;
      default: begin
        hit   = 1'b0;
        digit = '0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_serial_reader.sv
// Bit-serial 7-segment frame receiver with pattern-to-digit readback.
// Frames are 7 strobed bits, segment a first. After the 7th bit one DECODE
// cycle looks the pattern up and updates the held result registers.
// Ports:
//   io_in[0]    clock (rising edge)
//   io_in[1]    synchronous active-high reset
//   io_in[2]    serial segment bit
//   io_in[3]    strobe: bit accepted when high at a rising edge
//   io_in[7:4]  unused
//   io_out[3:0] decoded digit
//   io_out[4]   valid: last frame was a known pattern
//   io_out[5]   err: last frame was unknown or timed out
//   io_out[6]   busy: registered copy of "frame in progress"
//   io_out[7]   ftog: toggles per completed frame
module seg7_serial_reader
  import seg7_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic w_clk;
  logic w_rst;
  logic w_sdata;
  logic w_strobe;
  logic w_unused;

  assign w_clk    = io_in[IN_CLK];
  assign w_rst    = io_in[IN_RST];
  assign w_sdata  = io_in[IN_SDATA];
  assign w_strobe = io_in[IN_STROBE];
  assign w_unused = &{1'b0, io_in[7:4]};

  state_t     r_state;
  logic [2:0] r_count;
  logic [7:0] r_idle;
  logic [6:0] r_shift;
  logic [3:0] r_digit;
  logic       r_valid;
  logic       r_err;
  logic       r_busy;
  logic       r_ftog;

  logic       w_hit;
  logic [3:0] w_digit;

  seg7_pattern_decode u_decode (
    .pat   (r_shift),
    .hit   (w_hit),
    .digit (w_digit)
  );

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_idle  <= '0;
      r_shift <= '0;
      r_digit <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_ftog  <= 1'b0;
    end else begin
      // busy lags the state by one edge: high from the edge after the
      // first accepted bit through the edge that leaves DECODE.
      r_busy <= (r_state != IDLE);
      unique case (r_state)
        IDLE: begin
          if (w_strobe) begin
            r_shift[0] <= w_sdata;
            r_count    <= 3'd1;
            r_idle     <= '0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_strobe) begin
            r_shift[r_count] <= w_sdata;
            r_idle           <= '0;
            if (r_count == 3'(FRAME_BITS - 1)) begin
              r_count <= '0;
              r_state <= DECODE;
            end else begin
              r_count <= r_count + 3'd1;
            end
          end else if (r_idle == 8'(TIMEOUT - 1)) begin
            // this low cycle is the TIMEOUT-th in a row: abort the frame
            r_idle  <= '0;
            r_count <= '0;
            r_digit <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_idle <= r_idle + 8'd1;
          end
        end
        DECODE: begin
          r_digit <= w_hit ? w_digit : '0;
          r_valid <= w_hit;
          r_err   <= ~w_hit;
          r_ftog  <= ~r_ftog;
          r_count <= '0;
          r_idle  <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    io_out                              = '0;
    io_out[OUT_DIGIT_MSB:OUT_DIGIT_LSB] = r_digit;
    io_out[OUT_VALID]                   = r_valid;
    io_out[OUT_ERR]                     = r_err;
    io_out[OUT_BUSY]                    = r_busy;
    io_out[OUT_FTOG]                    = r_ftog;
  end

endmodule
